digit_buffer: RTL and testbench

DIGIT_BUFFER -- requirements
Module: digit_buffer

---
 rtl/digit_buffer.sv | 99 +++++++++
 tb/tb_digit_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/digit_buffer.sv
// digit_buffer: small first-word fall-through FIFO for digit codes produced by
// the result conversion stage. Captures one digit per digit_clk rising edge,
// exposes the head digit to the host, and keeps sticky overflow and
// character-toggle error flags.
module digit_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     digit_clk,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_flag,
  input  logic                     rd_req,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     flag_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             digit_clk_d;
  logic             armed;
  logic             last_flag;
  logic             push;
  logic             pop;
  logic             store;
  logic             drop;

  // armed stays low after reset until digit_clk has been seen low, so a strobe
  // already high at reset release is not mistaken for a new digit.
  always_comb begin
    push  = digit_clk & ~digit_clk_d & armed;
    pop   = rd_req & dout_valid;
    store = push & (~full | pop);
    drop  = push & full & ~pop;
  end

  // Strobe edge detection state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_clk_d <= 1'b0;
      armed       <= 1'b0;
    end else begin
      digit_clk_d <= digit_clk;
      armed       <= armed | ~digit_clk;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({store, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Digit storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= din;
  end

  // Sticky error flags; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      flag_err  <= 1'b0;
      last_flag <= 1'b0;
    end else begin
      overflow <= drop | (overflow & ~clr_err);
      flag_err <= (push & (din_flag == last_flag)) | (flag_err & ~clr_err);
      if (push) last_flag <= din_flag;
    end
  end

  assign dout       = mem[rd_ptr];
  assign dout_valid = (count != '0);
  assign full       = (count == CNT_FULL);

endmodule

// File: tb/tb_digit_buffer.sv
// Testbench for digit_buffer: queue scoreboard plus a small reference model of
// occupancy and sticky flags, checked after every clock.
module tb_digit_buffer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             digit_clk;
  logic [WIDTH-1:0] din;
  logic             din_flag;
  logic             rd_req;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic [2:0]       count;
  logic             overflow;
  logic             flag_err;

  digit_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .digit_clk  (digit_clk),
    .din        (din),
    .din_flag   (din_flag),
    .rd_req     (rd_req),
    .clr_err    (clr_err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .flag_err   (flag_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sbq[$];
  logic m_ovf     = 1'b0;
  logic m_ferr    = 1'b0;
  logic m_lastf   = 1'b0;
  logic m_prev_dc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, update the model, clock, compare.
  task automatic cyc(input logic dc, input logic [7:0] d, input logic f,
                     input logic rd, input logic clr);
    logic p_push, p_pop, was_full, set_ovf, set_ferr;
    digit_clk = dc;
    din       = d;
    din_flag  = f;
    rd_req    = rd;
    clr_err   = clr;
    p_push   = dc && !m_prev_dc;
    p_pop    = rd && (sbq.size() > 0);
    was_full = (sbq.size() == DEPTH);
    set_ovf  = 1'b0;
    set_ferr = 1'b0;
    if (p_pop) begin
      chk("pop_data", 32'(dout), 32'(sbq[0]));
      void'(sbq.pop_front());
    end
    if (p_push) begin
      if (was_full && !p_pop) set_ovf = 1'b1;
      else sbq.push_back(d);
      set_ferr = (f == m_lastf);
      m_lastf  = f;
    end
    m_ovf     = set_ovf | (m_ovf & ~clr);
    m_ferr    = set_ferr | (m_ferr & ~clr);
    m_prev_dc = dc;
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(sbq.size()));
    chk("dout_valid", 32'(dout_valid), 32'(sbq.size() != 0));
    chk("full", 32'(full), 32'(sbq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("flag_err", 32'(flag_err), 32'(m_ferr));
    if (sbq.size() != 0) chk("head", 32'(dout), 32'(sbq[0]));
  endtask

  task automatic push_f(input logic [7:0] d, input logic f);
    cyc(1'b1, d, f, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, f, 1'b0, 1'b0);
  endtask

  // Push with a correctly toggled character flag.
  task automatic push_t(input logic [7:0] d);
    push_f(d, ~m_lastf);
  endtask

  task automatic pop1();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; digit_clk = 1'b0; din = '0; din_flag = 1'b0;
    rd_req = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ferr", 32'(flag_err), 32'd0);
    reset = 1'b0;
    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Single digit, then a wide strobe that must push only once.
    push_f(8'h31, 1'b1);
    pop1();
    cyc(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    pop1();

    // Fill and overflow, in-order drain, then clear.
    for (int i = 1; i <= 5; i++) push_t(8'(i));
    for (int i = 0; i < 4; i++) pop1();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Pointer wrap.
    for (int i = 0; i < 3; i++) push_t(8'h10 + 8'(i));
    for (int i = 0; i < 3; i++) pop1();
    for (int i = 0; i < 4; i++) push_t(8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) pop1();

    // Flag error: repeat flag, clear, then clear coincident with a set.
    push_f(8'h41, ~m_lastf);
    push_f(8'h42, 1'b1);
    push_f(8'h43, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h44, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pop1();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Push + pop while full, then rd_req on empty, then push + rd_req on empty.
    for (int i = 0; i < 4; i++) push_t(8'h60 + 8'(i));
    cyc(1'b1, 8'h55, ~m_lastf, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pop1();
    pop1();
    cyc(1'b1, 8'h66, ~m_lastf, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    pop1();

    // Reset mid-stream with digit_clk held high through release.
    for (int i = 0; i < 3; i++) push_t(8'h70 + 8'(i));
    digit_clk = 1'b1;
    din = 8'hEE;
    #1;
    reset = 1'b1;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_valid", 32'(dout_valid), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.delete();
    m_ovf = 1'b0; m_ferr = 1'b0; m_lastf = 1'b0; m_prev_dc = 1'b1;
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push_f(8'h77, 1'b1);
    pop1();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
